pipelined_addsub: RTL and testbench

//  Parametrised N-bit adder/subtractor built from 1-bit full-adder cells.

---
 rtl/pipelined_addsub_pkg.sv | 12 +
 rtl/fa_cell.sv | 17 +
 rtl/pipelined_addsub.sv | 148 ++++++++++++++
 tb/tb_pipelined_addsub.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
//   DEFAULT_WIDTH / DEFAULT_STAGES : default operand width and slice count
//   MODE_ADD / MODE_SUB            : encodings of the sub input
package pipelined_addsub_pkg;

    localparam int unsigned DEFAULT_WIDTH  = 32;
    localparam int unsigned DEFAULT_STAGES = 4;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/fa_cell.sv
// Gate-level 1-bit full adder.
//   carry : carry out
//   sum   : a ^ b ^ cin
//   a, b  : operand bits
//   cin   : carry in
module fa_cell (
    output logic carry,
    output logic sum,
    input  logic a,
    input  logic b,
    input  logic cin
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined N-bit adder/subtractor. The ripple carry chain of WIDTH full-adder cells
// is cut into STAGES register slices of SEG bits each; one beat per cycle is accepted.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (a, b, cin, sub)
//   out_valid / out_ready: result handshake (sum, cout, ovf)
//   sub = 0 : sum = a + b + cin ; sub = 1 : sum = a - b - cin (cout = 1 means no borrow)
//   ovf : signed overflow (carry into MSB xor carry out of MSB)
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned SEG = WIDTH / STAGES;

    if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipelined_addsub: WIDTH must be >= 2 and a multiple of STAGES");
    end

    // Per-slice inputs: slice 0 sees the conditioned ports, slice k the registers of slice k-1.
    logic [WIDTH-1:0]  st_a [STAGES];
    logic [WIDTH-1:0]  st_b [STAGES];
    logic [WIDTH-1:0]  st_r [STAGES];
    logic [STAGES-1:0] st_c;
    logic [STAGES-1:0] st_v;

    logic [WIDTH-1:0]  fa_s;
    logic [STAGES-1:0] slice_co;
    logic [WIDTH-1:0]  r_nxt [STAGES];
    logic              ovf_d;
    logic [STAGES-1:0] rdy;

    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  r_q [STAGES];
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic              ovf_q;

    // Carry chain; each slice restarts from its registered carry-in.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        localparam int unsigned K = i / SEG;
        logic ci;
        logic co;
        if ((i % SEG) == 0) begin : g_first
            assign ci = st_c[K];
        end else begin : g_chain
            assign ci = g_bit[i-1].co;
        end
        fa_cell u_fa (
            .carry (co),
            .sum   (fa_s[i]),
            .a     (st_a[K][i]),
            .b     (st_b[K][i]),
            .cin   (ci)
        );
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign st_a[k] = a;
            assign st_b[k] = (sub == MODE_SUB) ? ~b : b;
            assign st_c[k] = (sub == MODE_SUB) ? ~cin : cin;
            assign st_r[k] = '0;
            assign st_v[k] = in_valid;
        end else begin : g_tail
            assign st_a[k] = a_q[k-1];
            assign st_b[k] = b_q[k-1];
            assign st_c[k] = c_q[k-1];
            assign st_r[k] = r_q[k-1];
            assign st_v[k] = v_q[k-1];
        end
        assign slice_co[k] = g_bit[(k+1)*SEG-1].co;
    end

    assign ovf_d = g_bit[WIDTH-1].ci ^ g_bit[WIDTH-1].co;

    // Each slice merges its own SEG result bits into the partial result handed down.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            r_nxt[k]                = st_r[k];
            r_nxt[k][k*SEG +: SEG]  = fa_s[k*SEG +: SEG];
        end
    end

    // ready_k = !valid_k || ready_{k+1}, unrolled: slice k is blocked only when it and every
    // slice downstream of it are full and the output is stalled.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            rdy[k] = out_ready || !(&(v_q | ((STAGES'(1) << k) - STAGES'(1))));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                r_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    v_q[k] <= st_v[k];
                end
                // Data only moves with a valid beat, so the output slice holds its last result.
                if (rdy[k] && st_v[k]) begin
                    a_q[k] <= st_a[k];
                    b_q[k] <= st_b[k];
                    r_q[k] <= r_nxt[k];
                    c_q[k] <= slice_co[k];
                end
            end
            if (rdy[STAGES-1] && st_v[STAGES-1]) begin
                ovf_q <= ovf_d;
            end
        end
    end

    // The last slice has no operand bits left to consume.
    logic unused_skew;
    assign unused_skew = ^{a_q[STAGES-1], b_q[STAGES-1]};

    assign in_ready  = rdy[0];
    assign out_valid = v_q[STAGES-1];
    assign sum       = r_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub (WIDTH=8, STAGES=4): directed vectors, random
// back-to-back beats, full-pipe stall, random backpressure and reset with beats in flight.
module tb_pipelined_addsub;

    localparam int unsigned W    = 8;
    localparam int unsigned S    = 4;
    localparam int          SMAX = 2 ** (W - 1) - 1;
    localparam int          SMIN = -(2 ** (W - 1));
    localparam int          UMAX = 2 ** W - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub_i;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    always #5 clk = ~clk;

    pipelined_addsub #(
        .WIDTH  (W),
        .STAGES (S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t sb_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    bit   bp_rand = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: exact integer arithmetic on the operands.
    function automatic exp_t model(input logic [W-1:0] va, input logic [W-1:0] vb,
                                   input logic vc, input logic vs);
        exp_t e;
        int ua, ub, sa, sb, c, u, s;
        ua = int'(va);
        ub = int'(vb);
        sa = int'($signed(va));
        sb = int'($signed(vb));
        c  = int'(vc);
        if (vs) begin
            u      = ua - ub - c;
            s      = sa - sb - c;
            e.cout = (u >= 0);
        end else begin
            u      = ua + ub + c;
            s      = sa + sb + c;
            e.cout = (u > UMAX);
        end
        e.sum = u[W-1:0];
        e.ovf = (s > SMAX) || (s < SMIN);
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vc, input logic vs);
        int waited;
        waited   = 0;
        a        = va;
        b        = vb;
        cin      = vc;
        sub_i    = vs;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back(model(va, vb, vc, vs));
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
            if (bp_rand) out_ready = 1'($urandom());
            waited++;
            if (waited > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", waited);
                break;
            end
        end
        in_valid = 1'b0;
        if (bp_rand) out_ready = 1'($urandom());
    endtask

    task automatic send_rand();
        send(W'($urandom()), W'($urandom()), 1'($urandom()), 1'($urandom()));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (bp_rand) out_ready = 1'($urandom());
        end
    endtask

    // Monitor: pops an expectation on every output transfer and checks stall stability.
    logic         stalled_prev = 1'b0;
    logic [W-1:0] held_sum;
    logic [1:0]   held_flags;
    exp_t         mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            stalled_prev = 1'b0;
        end else begin
            if (stalled_prev) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_sum", 32'(sum), 32'(held_sum));
                chk("hold_flags", 32'({cout, ovf}), 32'(held_flags));
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got sum 0x%0h, expected no output", sum);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("sum", 32'(sum), 32'(mon_e.sum));
                    chk("cout", 32'(cout), 32'(mon_e.cout));
                    chk("ovf", 32'(ovf), 32'(mon_e.ovf));
                end
            end
            stalled_prev = out_valid && !out_ready;
            held_sum     = sum;
            held_flags   = {cout, ovf};
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int t0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub_i     = 1'b0;
        out_ready = 1'b1;

        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Latency of a lone beat.
        send(8'h0F, 8'h01, 1'b0, 1'b0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        chk("latency", 32'(lat), 32'(S));
        @(posedge clk);
        #1;

        // Directed corner vectors.
        send(8'h7F, 8'h01, 1'b0, 1'b0);
        send(8'hFF, 8'h01, 1'b0, 1'b0);
        send(8'h05, 8'h07, 1'b0, 1'b1);
        send(8'h80, 8'h01, 1'b0, 1'b1);
        send(8'h00, 8'h00, 1'b1, 1'b1);
        send(8'hFF, 8'hFF, 1'b1, 1'b0);
        send(8'h7F, 8'h80, 1'b0, 1'b1);
        idle(8);

        // Back-to-back random beats: one accept per cycle.
        t0 = cyc;
        repeat (16) send_rand();
        chk("throughput", 32'(cyc - t0), 32'd16);
        idle(8);
        chk("drain_b2b", 32'(sb_q.size()), 32'd0);

        // Fill the pipe with the output stalled.
        out_ready = 1'b0;
        repeat (S) send_rand();
        a        = 8'h3C;
        b        = 8'h5A;
        cin      = 1'b1;
        sub_i    = 1'b0;
        in_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("full_in_ready", 32'(in_ready), 32'd0);
            chk("full_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(8'h3C, 8'h5A, 1'b1, 1'b0);
        idle(8);
        chk("drain_stall", 32'(sb_q.size()), 32'd0);

        // Random backpressure.
        bp_rand = 1'b1;
        repeat (40) send_rand();
        bp_rand   = 1'b0;
        out_ready = 1'b1;
        idle(12);
        chk("drain_bp", 32'(sb_q.size()), 32'd0);

        // Reset with three beats in flight and the oldest waiting at the output.
        send(8'h12, 8'h34, 1'b0, 1'b0);
        idle(8);
        out_ready = 1'b0;
        repeat (3) send_rand();
        idle(1);
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        sb_q.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        idle(10);
        chk("no_stale_valid", 32'(out_valid), 32'd0);

        // Pipe still works after the reset.
        send(8'hFF, 8'h01, 1'b0, 1'b0);
        send(8'h80, 8'h01, 1'b0, 1'b1);
        idle(8);
        chk("drain_final", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
